// File: rtl/add4_pkg.sv
// Shared constants and state type for the bit-serial "+4" unit.
package add4_pkg;

    localparam int                    ADD4_WIDTH = 8;
    localparam logic [ADD4_WIDTH-1:0] ADD4_CONST = 8'h04;
    localparam int                    ADD4_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } add4_state_e;

endpackage

// File: rtl/full_adder_1_bit.sv
// Single full-adder cell; the only arithmetic element of the serial adder.
module full_adder_1_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/add_4_serial.sv
// Bit-serial A + 4 over eight cycles with a start/busy/done handshake.
// Optional signed-overflow output enabled by defining ADD4_OVF_FLAG_EN.
module add_4_serial
    import add4_pkg::*;
#(
    parameter int              WIDTH  = ADD4_WIDTH,
    parameter logic [WIDTH-1:0] ADDEND = ADD4_CONST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADD4_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [ADD4_CNT_W-1:0] LAST_BIT = ADD4_CNT_W'(WIDTH - 1);

    add4_state_e            state_q;
    logic [WIDTH-1:0]       shift_q, shift_d;
    logic [WIDTH-2:0]       res_q, res_d;
    logic [ADD4_CNT_W-1:0]  cnt_q;
    logic                   carry_q;
    logic                   busy_q, done_q, cout_q;
    logic [WIDTH-1:0]       sum_q;
    logic                   fa_b, fa_s, fa_co;
    logic                   accept;

    // DONE also accepts, so a held start yields one result every 9 cycles.
    assign accept = start && (state_q == IDLE || state_q == DONE);

    always_comb begin
        fa_b    = ADDEND[cnt_q];
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-2:1]};
    end

    full_adder_1_bit u_fa (
        .a_i   (shift_q[0]),
        .b_i   (fa_b),
        .cin_i (carry_q),
        .sum_o (fa_s),
        .cout_o(fa_co)
    );

`ifdef ADD4_OVF_FLAG_EN
    logic ovf_q;
    assign ovf = ovf_q;
`endif

    // NOTE: every register here uses <= so all flops see the pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef ADD4_OVF_FLAG_EN
            ovf_q   <= 1'b0;
`endif
        end else if (accept) begin
            state_q <= RUN;
            shift_q <= A;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    shift_q <= shift_d;
                    res_q   <= res_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= {fa_s, res_q};
                        cout_q  <= fa_co;
`ifdef ADD4_OVF_FLAG_EN
                        ovf_q   <= carry_q ^ fa_co;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_add_4_serial.sv
// Self-checking bench for add_4_serial: arithmetic reference model plus directed vectors.
module tb_add_4_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] A = 8'h00;
    logic       busy, done, cout;
    logic [7:0] sum;
`ifdef ADD4_OVF_FLAG_EN
    logic       ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    add_4_serial dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef ADD4_OVF_FLAG_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed since the accepting edge, and the accepted operand.
    int         since = 0;
    logic [7:0] op = 8'h00;
    logic [7:0] m_sum = 8'h00;
    logic       m_cout = 1'b0;
    logic       m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            since  = 0;
            m_sum  = 8'h00;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else begin
            if (since == 8) begin
                m_sum  = 8'((int'(op) + 4) % 256);
                m_cout = (int'(op) + 4) > 255;
                m_ovf  = (int'($signed(op)) + 4) > 127;
            end
            if ((since == 0 || since == 9) && start) begin
                op    = A;
                since = 1;
            end else if (since == 9) begin
                since = 0;
            end else if (since != 0) begin
                since++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("busy", busy, (since >= 1 && since <= 8));
            check("done", done, (since == 9));
            check("sum", sum, m_sum);
            check("cout", cout, m_cout);
`ifdef ADD4_OVF_FLAG_EN
            check("ovf", ovf, m_ovf);
`endif
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] exp_sum, input logic exp_cout,
                          output int lat, output int busy_cnt);
        @(negedge clk);
        A = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = ~a;
        lat = 1;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", done, 1);
        check("op_sum", sum, exp_sum);
        check("op_cout", cout, exp_cout);
    endtask

    initial begin
        int lat, bc, dones, first_done, second_done;
        logic [7:0] seen_sum;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 8'h00);
        check("rst_cout", cout, 0);
`ifdef ADD4_OVF_FLAG_EN
        check("rst_ovf", ovf, 0);
`endif

        run_op(8'h00, 8'h04, 1'b0, lat, bc);
        check("latency", lat, 9);
        check("busy_cycles", bc, 8);
        run_op(8'hFE, 8'h02, 1'b1, lat, bc);
        run_op(8'hFB, 8'hFF, 1'b0, lat, bc);
        run_op(8'h33, 8'h37, 1'b0, lat, bc);
        run_op(8'hFF, 8'h03, 1'b1, lat, bc);
        run_op(8'hFC, 8'h00, 1'b1, lat, bc);
        run_op(8'h7D, 8'h81, 1'b0, lat, bc);
`ifdef ADD4_OVF_FLAG_EN
        check("ovf_7d", ovf, 1);
`endif
        run_op(8'h10, 8'h14, 1'b0, lat, bc);
`ifdef ADD4_OVF_FLAG_EN
        check("ovf_10", ovf, 0);
`endif

        // Second start during RUN must be dropped.
        @(negedge clk);
        A = 8'h20;
        start = 1'b1;
        dones = 0;
        seen_sum = 8'h00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            start = (i == 4);
            A = (i == 4) ? 8'h99 : 8'h55;
            if (done === 1'b1) begin
                dones++;
                seen_sum = sum;
            end
        end
        start = 1'b0;
        check("ignored_start_dones", dones, 1);
        check("ignored_start_sum", seen_sum, 8'h24);

        // Reset in cycle 5 of RUN aborts without a done pulse.
        @(negedge clk);
        A = 8'hFE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 8'h00);
        check("abort_cout", cout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        run_op(8'h41, 8'h45, 1'b0, lat, bc);
        check("post_abort_latency", lat, 9);

        // Start held high: results every 9 cycles.
        @(negedge clk);
        A = 8'h01;
        start = 1'b1;
        dones = 0;
        first_done = -1;
        second_done = -1;
        for (int i = 1; i <= 30 && dones < 2; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) first_done = i;
                else second_done = i;
            end
        end
        start = 1'b0;
        check("b2b_dones", dones, 2);
        check("b2b_first", first_done, 9);
        check("b2b_gap", second_done - first_done, 9);
        check("b2b_sum", sum, 8'h05);
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
